// File: rtl/hdc_encode_sched.sv
// Spatial-encoder sequencer for the HDC seizure-detection datapath.
// For each sample it clears the bundling accumulator, walks the channels in order
// (issuing item/level memory reads), lets the bind/accumulate pipeline drain,
// fires the majority threshold and holds the result under a valid/ready handshake.
// All outputs come straight from flops; they are loaded from next-state decode.
module hdc_encode_sched #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned LEVELS       = 64,
  parameter int unsigned MEM_LAT      = 1,
  localparam int unsigned LVL_W       = $clog2(LEVELS),
  localparam int unsigned CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_start,
  input  logic [NUM_CHANNELS*LVL_W-1:0] i_sample_levels,
  input  logic [NUM_CHANNELS-1:0]       i_ch_mask,
  output logic                          o_busy,
  output logic                          o_mem_rd_en,
  output logic [CH_W-1:0]               o_im_addr,
  output logic [LVL_W-1:0]              o_lm_addr,
  output logic                          o_bind_en,
  output logic                          o_acc_clr,
  output logic                          o_acc_en,
  output logic                          o_acc_thresh,
  output logic [CH_W:0]                 o_acc_count,
  output logic                          o_out_valid,
  input  logic                          i_out_ready
);

  // Drain counter runs 0..MEM_LAT, i.e. MEM_LAT+1 cycles.
  localparam int unsigned DRAIN_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StDrain,
    StFinal,
    StHold
  } state_e;

  // Control state
  state_e                        r_state;
  state_e                        w_state_d;
  logic [CH_W-1:0]               r_ch;
  logic [CH_W-1:0]               w_ch_d;
  logic [DRAIN_W-1:0]            r_drain;
  logic [DRAIN_W-1:0]            w_drain_d;
  logic                          w_latch;

  // Sample captured at start
  logic [NUM_CHANNELS*LVL_W-1:0] r_levels;
  logic [NUM_CHANNELS-1:0]       r_mask;
  logic [LVL_W-1:0]              w_lvl [NUM_CHANNELS];

  // Registered outputs and their next values
  logic                          r_busy;
  logic                          r_mem_rd_en;
  logic [CH_W-1:0]               r_im_addr;
  logic [LVL_W-1:0]              r_lm_addr;
  logic                          r_acc_clr;
  logic                          r_acc_thresh;
  logic [CH_W:0]                 r_acc_count;
  logic                          r_out_valid;
  logic                          w_busy_d;
  logic                          w_rd_en_d;
  logic [CH_W-1:0]               w_im_addr_d;
  logic [LVL_W-1:0]              w_lm_addr_d;
  logic                          w_acc_clr_d;
  logic                          w_acc_thresh_d;
  logic [CH_W:0]                 w_count_d;
  logic                          w_out_valid_d;

  // Read-strobe delay line: tap MEM_LAT-1 is bind_en, tap MEM_LAT is acc_en.
  logic [MEM_LAT:0]              r_pipe;

  // Unpack the latched level vector into per-channel entries.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_lvl[c] = r_levels[c*LVL_W +: LVL_W];
    end
  end

  // Next-state logic for the sequencer.
  always_comb begin
    w_state_d = r_state;
    w_ch_d    = r_ch;
    w_drain_d = r_drain;
    w_latch   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StClear;
          w_latch   = 1'b1;
        end
      end
      StClear: begin
        w_state_d = StIssue;
        w_ch_d    = '0;
      end
      StIssue: begin
        if (r_ch == CH_W'(NUM_CHANNELS - 1)) begin
          w_state_d = StDrain;
          w_drain_d = '0;
        end else begin
          w_ch_d = r_ch + 1'b1;
        end
      end
      StDrain: begin
        // Fixed length regardless of mask: covers the last possible acc_en slot.
        if (r_drain == DRAIN_W'(MEM_LAT)) begin
          w_state_d = StFinal;
        end else begin
          w_drain_d = r_drain + 1'b1;
        end
      end
      StFinal: begin
        w_state_d = StHold;
      end
      StHold: begin
        if (i_out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state so every output can be a plain flop.
  always_comb begin
    w_busy_d       = (w_state_d != StIdle);
    w_acc_clr_d    = (w_state_d == StClear);
    w_acc_thresh_d = (w_state_d == StFinal);
    w_out_valid_d  = (w_state_d == StHold);
    w_rd_en_d      = 1'b0;
    w_im_addr_d    = '0;
    w_lm_addr_d    = '0;
    if (w_state_d == StIssue) begin
      // Masked channels keep their slot (bubble) but do not strobe the memories.
      w_rd_en_d   = r_mask[w_ch_d];
      w_im_addr_d = w_ch_d;
      w_lm_addr_d = w_lvl[w_ch_d];
    end
    w_count_d = r_acc_count;
    if (w_state_d == StClear) begin
      w_count_d = '0;
    end else if (w_rd_en_d) begin
      w_count_d = r_acc_count + 1'b1;
    end
  end

  // State register and sample capture.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state  <= StIdle;
      r_ch     <= '0;
      r_drain  <= '0;
      r_levels <= '0;
      r_mask   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ch    <= w_ch_d;
      r_drain <= w_drain_d;
      if (w_latch) begin
        r_levels <= i_sample_levels;
        r_mask   <= i_ch_mask;
      end
    end
  end

  // Output registers.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_busy       <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_im_addr    <= '0;
      r_lm_addr    <= '0;
      r_acc_clr    <= 1'b0;
      r_acc_thresh <= 1'b0;
      r_acc_count  <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_busy       <= w_busy_d;
      r_mem_rd_en  <= w_rd_en_d;
      r_im_addr    <= w_im_addr_d;
      r_lm_addr    <= w_lm_addr_d;
      r_acc_clr    <= w_acc_clr_d;
      r_acc_thresh <= w_acc_thresh_d;
      r_acc_count  <= w_count_d;
      r_out_valid  <= w_out_valid_d;
    end
  end

  // Delay line for memory-read strobes; reset flushes in-flight issues.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[MEM_LAT-1:0], r_mem_rd_en};
    end
  end

  assign o_busy       = r_busy;
  assign o_mem_rd_en  = r_mem_rd_en;
  assign o_im_addr    = r_im_addr;
  assign o_lm_addr    = r_lm_addr;
  assign o_bind_en    = r_pipe[MEM_LAT-1];
  assign o_acc_clr    = r_acc_clr;
  assign o_acc_en     = r_pipe[MEM_LAT];
  assign o_acc_thresh = r_acc_thresh;
  assign o_acc_count  = r_acc_count;
  assign o_out_valid  = r_out_valid;

endmodule

// File: tb/tb_hdc_encode_sched.sv
// Directed bench for hdc_encode_sched: dut_a uses MEM_LAT=1, dut_b uses MEM_LAT=3.
// Cycle numbering: cycle 0 is the cycle in which start is high; outputs are sampled
// on the falling edge, so trace bit c holds the value seen during cycle c.
module tb_hdc_encode_sched;

  logic        clk;
  logic        nrst;
  logic        start_a, start_b;
  logic        ready_a, ready_b;
  logic [23:0] levels;
  logic [3:0]  mask;

  logic       busy_a, rd_a, bind_a, clr_a, acc_a, thr_a, val_a;
  logic [1:0] im_a;
  logic [5:0] lm_a;
  logic [2:0] cnt_a;
  logic       busy_b, rd_b, bind_b, clr_b, acc_b, thr_b, val_b;
  logic [1:0] im_b;
  logic [5:0] lm_b;
  logic [2:0] cnt_b;

  int n_checks;
  int n_fail;

  logic [15:0] tr_rd, tr_bind, tr_acc, tr_clr, tr_thr, tr_val, tr_busy;
  logic [1:0]  tr_im [16];
  logic [5:0]  tr_lm [16];
  logic [5:0]  exp_lm [4];

  // levels {ch3,ch2,ch1,ch0} = {63,0,10,3}
  localparam logic [23:0] LV1 = {6'd63, 6'd0, 6'd10, 6'd3};

  hdc_encode_sched #(.NUM_CHANNELS(4), .LEVELS(64), .MEM_LAT(1)) dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_start(start_a), .i_sample_levels(levels),
    .i_ch_mask(mask), .o_busy(busy_a), .o_mem_rd_en(rd_a), .o_im_addr(im_a),
    .o_lm_addr(lm_a), .o_bind_en(bind_a), .o_acc_clr(clr_a), .o_acc_en(acc_a),
    .o_acc_thresh(thr_a), .o_acc_count(cnt_a), .o_out_valid(val_a), .i_out_ready(ready_a)
  );

  hdc_encode_sched #(.NUM_CHANNELS(4), .LEVELS(64), .MEM_LAT(3)) dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_start(start_b), .i_sample_levels(levels),
    .i_ch_mask(mask), .o_busy(busy_b), .o_mem_rd_en(rd_b), .o_im_addr(im_b),
    .o_lm_addr(lm_b), .o_bind_en(bind_b), .o_acc_clr(clr_b), .o_acc_en(acc_b),
    .o_acc_thresh(thr_b), .o_acc_count(cnt_b), .o_out_valid(val_b), .i_out_ready(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a start for one cycle (cycle 0) on the selected DUT.
  task automatic launch(input int sel, input logic [3:0] m, input logic [23:0] lv);
    @(negedge clk);
    levels = lv;
    mask   = m;
    if (sel == 0) start_a = 1'b1;
    else          start_b = 1'b1;
    tr_rd = '0; tr_bind = '0; tr_acc = '0; tr_clr = '0;
    tr_thr = '0; tr_val = '0; tr_busy = '0;
    for (int i = 0; i < 16; i++) begin
      tr_im[i] = '0;
      tr_lm[i] = '0;
    end
  endtask

  // Record cycles 1..ncyc of the selected DUT.
  task automatic capture(input int sel, input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (sel == 0) begin
        tr_rd[c] = rd_a;  tr_bind[c] = bind_a; tr_acc[c] = acc_a; tr_clr[c] = clr_a;
        tr_thr[c] = thr_a; tr_val[c] = val_a; tr_busy[c] = busy_a;
        tr_im[c] = im_a;  tr_lm[c] = lm_a;
      end else begin
        tr_rd[c] = rd_b;  tr_bind[c] = bind_b; tr_acc[c] = acc_b; tr_clr[c] = clr_b;
        tr_thr[c] = thr_b; tr_val[c] = val_b; tr_busy[c] = busy_b;
        tr_im[c] = im_b;  tr_lm[c] = lm_b;
      end
    end
  endtask

  task automatic handshake_a(input string tag);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk({tag, "_val_after_hs"}, 32'(val_a), 32'd0);
    chk({tag, "_busy_after_hs"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nrst = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    levels = '0; mask = '0;
    exp_lm[0] = 6'd3; exp_lm[1] = 6'd10; exp_lm[2] = 6'd0; exp_lm[3] = 6'd63;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs_a", {20'd0, busy_a, rd_a, bind_a, clr_a, acc_a, thr_a, val_a, im_a,
        lm_a, cnt_a}, 32'd0);
    chk("rst_outs_b", {20'd0, busy_b, rd_b, bind_b, clr_b, acc_b, thr_b, val_b, im_b,
        lm_b, cnt_b}, 32'd0);
    nrst = 1'b1;

    // 1: all channels, MEM_LAT=1
    launch(0, 4'b1111, LV1);
    capture(0, 10);
    chk("t1_clr",  32'(tr_clr),  32'h0002);
    chk("t1_rd",   32'(tr_rd),   32'h003C);
    chk("t1_bind", 32'(tr_bind), 32'h0078);
    chk("t1_acc",  32'(tr_acc),  32'h00F0);
    chk("t1_thr",  32'(tr_thr),  32'h0100);
    chk("t1_val",  32'(tr_val),  32'h0600);
    chk("t1_busy", 32'(tr_busy), 32'h07FE);
    for (int c = 2; c <= 5; c++) begin
      chk("t1_im", 32'(tr_im[c]), 32'(c - 2));
      chk("t1_lm", 32'(tr_lm[c]), 32'(exp_lm[c-2]));
    end
    chk("t1_count", 32'(cnt_a), 32'd4);
    handshake_a("t1");

    // 2: mask 0101, bubbles in slots 3 and 5
    launch(0, 4'b0101, LV1);
    capture(0, 10);
    chk("t2_rd",    32'(tr_rd),  32'h0014);
    chk("t2_bind",  32'(tr_bind), 32'h0028);
    chk("t2_acc",   32'(tr_acc), 32'h0050);
    chk("t2_thr",   32'(tr_thr), 32'h0100);
    chk("t2_lm4",   32'(tr_lm[4]), 32'd0);
    chk("t2_im4",   32'(tr_im[4]), 32'd2);
    chk("t2_count", 32'(cnt_a), 32'd2);
    handshake_a("t2");

    // 3: all masked
    launch(0, 4'b0000, LV1);
    capture(0, 10);
    chk("t3_rd",    32'(tr_rd),   32'h0000);
    chk("t3_bind",  32'(tr_bind), 32'h0000);
    chk("t3_acc",   32'(tr_acc),  32'h0000);
    chk("t3_clr",   32'(tr_clr),  32'h0002);
    chk("t3_thr",   32'(tr_thr),  32'h0100);
    chk("t3_val",   32'(tr_val),  32'h0600);
    chk("t3_count", 32'(cnt_a),   32'd0);
    handshake_a("t3");

    // 4: backpressure in HOLD, start ignored while holding and at the handshake
    launch(0, 4'b1111, LV1);
    capture(0, 9);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_val",  32'(val_a),  32'd1);
      chk("t4_hold_busy", 32'(busy_a), 32'd1);
      start_a = (k == 2);
      @(negedge clk);
    end
    chk("t4_count_hold", 32'(cnt_a), 32'd4);
    start_a = 1'b1;
    ready_a = 1'b1;
    chk("t4_val_hs", 32'(val_a), 32'd1);
    @(negedge clk);
    start_a = 1'b0;
    ready_a = 1'b0;
    chk("t4_val_idle",  32'(val_a),  32'd0);
    chk("t4_busy_idle", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("t4_no_restart", {30'd0, busy_a, clr_a}, 32'd0);
    launch(0, 4'b1111, LV1);
    capture(0, 10);
    chk("t4_new_clr", 32'(tr_clr), 32'h0002);
    chk("t4_new_rd",  32'(tr_rd),  32'h003C);
    chk("t4_new_thr", 32'(tr_thr), 32'h0100);
    chk("t4_new_val", 32'(tr_val), 32'h0600);
    handshake_a("t4");

    // 5: reset at cycle 4 of a running sample
    launch(0, 4'b1111, LV1);
    capture(0, 4);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("t5_outs_c5", {20'd0, busy_a, rd_a, bind_a, clr_a, acc_a, thr_a, val_a, im_a,
        lm_a, cnt_a}, 32'd0);
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk);
      chk("t5_no_acc",  32'(acc_a),  32'd0);
      chk("t5_no_bind", 32'(bind_a), 32'd0);
      chk("t5_idle",    32'(busy_a), 32'd0);
    end
    launch(0, 4'b1111, LV1);
    capture(0, 10);
    chk("t5_clr", 32'(tr_clr), 32'h0002);
    chk("t5_rd",  32'(tr_rd),  32'h003C);
    chk("t5_acc", 32'(tr_acc), 32'h00F0);
    chk("t5_thr", 32'(tr_thr), 32'h0100);
    chk("t5_val", 32'(tr_val), 32'h0600);
    chk("t5_count", 32'(cnt_a), 32'd4);
    handshake_a("t5");

    // 6: MEM_LAT=3 instance
    launch(1, 4'b1111, LV1);
    capture(1, 12);
    chk("t6_clr",  32'(tr_clr),  32'h0002);
    chk("t6_rd",   32'(tr_rd),   32'h003C);
    chk("t6_bind", 32'(tr_bind), 32'h01E0);
    chk("t6_acc",  32'(tr_acc),  32'h03C0);
    chk("t6_thr",  32'(tr_thr),  32'h0400);
    chk("t6_val",  32'(tr_val),  32'h1800);
    chk("t6_lm5",  32'(tr_lm[5]), 32'd63);
    chk("t6_count", 32'(cnt_b),  32'd4);
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    chk("t6_val_after_hs",  32'(val_b),  32'd0);
    chk("t6_busy_after_hs", 32'(busy_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdc_encode_sched.md
Name: hdc_encode_sched

Overview:
- Sequencer for the spatial encoder of the HDC seizure-detection datapath.
- Per sample: clears the bundling accumulator, then walks the channels. For each channel it reads the channel item-memory HV and the quantized level HV, fires the XOR binder, accumulates the bound HV, and finally triggers the majority threshold.
- Presents the finished sample HV with a valid/ready handshake toward the temporal/associative stage.

Parameters:
NUM_CHANNELS, 4, number of EEG channels bundled per sample
LEVELS, 64, number of quantization levels (LVL_W = $clog2(LEVELS))
MEM_LAT, 1, read latency of item/level memories in cycles (>=1)
CH_W, $clog2(NUM_CHANNELS), channel index width (derived, do not override)

Ports:
clk  input  1  clock, rising edge
nrst  input  1  reset, synchronous, active-low
start  input  1  request to encode one sample; accepted only in IDLE
sample_levels  input  NUM_CHANNELS*LVL_W  level index per channel; channel c at bits [c*LVL_W +: LVL_W]
ch_mask  input  NUM_CHANNELS  1 = channel included; sampled with start
busy  output  1  high in every state except IDLE
mem_rd_en  output  1  read strobe to item and level memories
im_addr  output  CH_W  item-memory address (channel index)
lm_addr  output  LVL_W  level-memory address
bind_en  output  1  binder input valid; memory data present this cycle
acc_clr  output  1  clear bundling accumulator
acc_en  output  1  add registered binder output into accumulator
acc_thresh  output  1  apply majority threshold; threshold = acc_count/2
acc_count  output  CH_W+1  number of channels bundled this sample
out_valid  output  1  sample HV ready at accumulator output
out_ready  input  1  downstream accepts sample HV

Behaviour:
- All outputs are registered.
- Reset (nrst=0 at a clk edge), with or without an operation in progress:
  - State goes to IDLE.
  - All outputs go to 0, including addresses and acc_count.
  - Internal valid pipelines are flushed; no bind_en or acc_en fires after reset for issues made before it.
  - Reset wins over start.
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, FINAL, HOLD.
- IDLE:
  - On start=1: latch sample_levels and ch_mask, go to CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - acc_clr=1 for exactly 1 cycle; acc_count is cleared to 0.
  - Go to ISSUE with channel counter ch=0.
- ISSUE:
  - Exactly NUM_CHANNELS cycles, one per channel, in order ch = 0..NUM_CHANNELS-1.
  - im_addr=ch and lm_addr=latched level[ch] in every ISSUE cycle.
  - mem_rd_en = latched ch_mask[ch]; masked channels leave a bubble, they are not compacted.
  - acc_count increments for each issued channel.
  - After ch = NUM_CHANNELS-1, go to DRAIN.
- Pipeline timing:
  - bind_en = mem_rd_en delayed MEM_LAT cycles.
  - acc_en = mem_rd_en delayed MEM_LAT+1 cycles (binder output is registered).
- DRAIN:
  - Wait until the cycle after the last possible acc_en slot, i.e. MEM_LAT+1 cycles after ISSUE ends. The duration is the same regardless of mask.
  - Then go to FINAL.
- FINAL:
  - acc_thresh=1 for exactly 1 cycle, then go to HOLD.
- HOLD:
  - out_valid=1, held stable until out_ready=1 is sampled.
  - In the handshake cycle out_valid is still 1; next cycle state is IDLE and out_valid=0.
  - A start in the same cycle as the handshake is ignored.
  - out_ready outside HOLD is ignored.
- Fixed latency with start accepted at cycle 0, N = NUM_CHANNELS:
  - acc_clr at cycle 1.
  - mem_rd_en slots at cycles 2..N+1.
  - acc_en slots at cycles 3+MEM_LAT..N+MEM_LAT+2.
  - acc_thresh at cycle N+MEM_LAT+3.
  - out_valid from cycle N+MEM_LAT+4.
- All channels masked:
  - Sequence and timing are unchanged.
  - No mem_rd_en, bind_en or acc_en pulses.
  - acc_count=0 and acc_thresh still pulses, yielding the all-zero HV.
- acc_count holds its value from the end of ISSUE until the next CLEAR.

Test Plan:
1. Reset, N=4, MEM_LAT=1, mask=4'b1111, levels={3,10,0,63}, start at cycle 0 -> acc_clr @1; mem_rd_en @2..5 with (im,lm)=(0,3),(1,10),(2,0),(3,63); bind_en @3..6; acc_en @4..7; acc_thresh @8; out_valid @9; acc_count=4.
2. mask=4'b0101 -> mem_rd_en only @2 and @4; acc_en only @4 and @6; acc_thresh still @8; acc_count=2.
3. mask=4'b0000 -> no mem_rd_en, bind_en or acc_en; acc_thresh @8; out_valid @9; acc_count=0.
4. out_ready held low 5 cycles in HOLD with start pulsed in that window -> out_valid stays 1, busy stays 1, start ignored; out_ready=1 -> IDLE next cycle; a new start is then accepted normally.
5. nrst=0 at cycle 4 of case 1 -> every output is 0 at cycle 5; no acc_en at cycles 5..7; a start after nrst returns high reproduces case 1 timing.
6. MEM_LAT=3, N=4 -> bind_en @5..8, acc_en @6..9, acc_thresh @10, out_valid @11.
